// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA definitions: 640x480@60 timing constants, colour
//               triple typedef and sync polarity enum.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // 640x480@60 with a 25 MHz pixel rate
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // Default channel width for the colour triple
  localparam int RGB_COLOR_W = 8;

  typedef struct packed {
    logic [RGB_COLOR_W-1:0] r;
    logic [RGB_COLOR_W-1:0] g;
    logic [RGB_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    POL_ACTIVE_LOW  = 1'b0,
    POL_ACTIVE_HIGH = 1'b1
  } pol_e;

endpackage
`default_nettype wire

// File: rtl/vga_pix_ce.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_ce
// Description : Pixel-rate enable generator. Produces a one-clk pulse every
//               CLK_DIV system clocks; reusable by application logic.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_ce #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_ce
);

  localparam int            DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_d;

  // Phase counter; the enable is registered from the terminal count so the
  // first pulse lands CLK_DIV clocks after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d    <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= (r_d == D_LAST);
      r_d    <= (r_d == D_LAST) ? '0 : r_d + DW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster engine: pixel enable, H/V counters,
//               sync/blank decode, alignment delay line and DAC output register.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int PIPE     = 2
) (
  input  logic                                              clk,
  input  logic                                              reset,
  output logic                                              pix_ce,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      y,
  output logic                                              req,
  input  logic [3*COLOR_W-1:0]                              rgb_in,
  output logic                                              vga_hs,
  output logic                                              vga_vs,
  output logic                                              vga_blank_n,
  output logic                                              vga_sync_n,
  output logic [COLOR_W-1:0]                                red,
  output logic [COLOR_W-1:0]                                green,
  output logic [COLOR_W-1:0]                                blue,
  output logic                                              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam pol_e HS_LEVEL = pol_e'(HS_POL);
  localparam pol_e VS_LEVEL = pol_e'(VS_POL);

  // Reject degenerate timings at elaboration
  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIPE < 0) begin : g_param_check
    $error("vga_timing_gen: timing regions and CLK_DIV must be 1 or more, PIPE 0 or more");
  end

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_act;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic [2:0]    w_ctl_raw;
  logic [2:0]    w_ctl_dly;
  logic          w_act_dly;
  logic          w_hs_dly;
  logic          w_vs_dly;

  vga_pix_ce #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce (
    .clk    (clk),
    .reset  (reset),
    .pix_ce (pix_ce)
  );

  // Raster counters: h every tick, v on each h wrap, both wrap on the frame's last pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pix_ce) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  // Region decode straight from the counters
  always_comb begin
    w_act     = (r_h < H_ACT_END) && (r_v < V_ACT_END);
    w_hs_raw  = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
    w_vs_raw  = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);
    w_ctl_raw = {w_act, w_hs_raw, w_vs_raw};
  end

  if (PIPE > 0) begin : g_pipe
    logic [2:0] r_stage [PIPE];

    // Delay the control bits by the pixel source's latency; cleared stages mean blanked, no sync
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE; i++) r_stage[i] <= '0;
      end else if (pix_ce) begin
        r_stage[0] <= w_ctl_raw;
        for (int i = 1; i < PIPE; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign w_ctl_dly = r_stage[PIPE-1];
  end else begin : g_no_pipe
    assign w_ctl_dly = w_ctl_raw;
  end

  assign {w_act_dly, w_hs_dly, w_vs_dly} = w_ctl_dly;

  // DAC-side register: syncs at their configured level, colour forced to 0 while blanked
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs      <= (HS_LEVEL == POL_ACTIVE_LOW);
      vga_vs      <= (VS_LEVEL == POL_ACTIVE_LOW);
      vga_blank_n <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else if (pix_ce) begin
      vga_hs      <= (HS_LEVEL == POL_ACTIVE_HIGH) ? w_hs_dly : ~w_hs_dly;
      vga_vs      <= (VS_LEVEL == POL_ACTIVE_HIGH) ? w_vs_dly : ~w_vs_dly;
      vga_blank_n <= w_act_dly;
      red         <= w_act_dly ? rgb_in[3*COLOR_W-1 -: COLOR_W] : '0;
      green       <= w_act_dly ? rgb_in[2*COLOR_W-1 -: COLOR_W] : '0;
      blue        <= w_act_dly ? rgb_in[COLOR_W-1   -: COLOR_W] : '0;
    end
  end

  assign x           = r_h;
  assign y           = r_v;
  assign req         = w_act;
  assign frame_start = pix_ce && (r_h == '0) && (r_v == '0);
  assign vga_sync_n  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. A closed-form raster
//               model predicts every output each cycle for two configurations;
//               directed measurements pin periods, widths and pixel values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    bit pix;
    int x;
    int y;
    bit req;
    bit fs;
    bit hs;
    bit vs;
    bit bn;
    int r;
    int g;
    int b;
  } exp_t;

  logic clk;
  logic reset;
  logic reset5;

  // Main instance: 640-wide line, short frame, CLK_DIV=2, PIPE=2
  logic        pix_ce, req, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
  logic [9:0]  x;
  logic [3:0]  y;
  logic [23:0] rgb_in;
  logic [7:0]  red, green, blue;

  // Tiny instance: CLK_DIV=1, active-high hsync, PIPE=0
  logic        pix_ce5, req5, hs5, vs5, bn5, sn5, fs5;
  logic [2:0]  x5, y5;
  logic [23:0] rgb_in5;
  logic [7:0]  red5, green5, blue5;

  int checks = 0;
  int errors = 0;
  bit done   = 0;
  bit chk_en = 0;
  bit meas_en = 0;
  int mc  = 0;
  int mc5 = 0;

  logic [23:0] src1, src2;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .PIPE(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .x(x), .y(y), .req(req),
    .rgb_in(rgb_in), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(8), .PIPE(0)
  ) dut5 (
    .clk(clk), .reset(reset5), .pix_ce(pix_ce5), .x(x5), .y(y5), .req(req5),
    .rgb_in(rgb_in5), .vga_hs(hs5), .vga_vs(vs5), .vga_blank_n(bn5),
    .vga_sync_n(sn5), .red(red5), .green(green5), .blue(blue5),
    .frame_start(fs5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pixel source for the main instance: two-tick latency
  always @(posedge clk) begin
    if (reset) begin
      src1 <= '0;
      src2 <= '0;
    end else if (pix_ce) begin
      src1 <= {x[7:0], 4'b0000, y, 8'hA5};
      src2 <= src1;
    end
  end
  assign rgb_in  = src2;
  assign rgb_in5 = {5'b00000, x5, 5'b00000, y5, 8'h3C};

  // Clock edges seen with reset low since the last reset
  always @(posedge clk) begin
    mc  <= reset  ? 0 : mc + 1;
    mc5 <= reset5 ? 0 : mc5 + 1;
  end

  // Raster model: ticks elapsed -> position; output register shows tick n-1-PIPE
  function automatic exp_t model(input int c, input int cd,
                                 input int ha, input int hf, input int hsn, input int hb,
                                 input int va, input int vf, input int vsn, input int vb,
                                 input int pipe, input bit hpol, input bit vpol, input int bl);
    exp_t e;
    int ht, vt, ft, n, p, q, hq, vq;
    bit act, hsr, vsr;
    ht = ha + hf + hsn + hb;
    vt = va + vf + vsn + vb;
    ft = ht * vt;
    n  = (c == 0) ? 0 : (c - 1) / cd;
    e.pix = (c >= 1) && (c % cd == 0);
    p     = n % ft;
    e.x   = p % ht;
    e.y   = p / ht;
    e.req = (e.x < ha) && (e.y < va);
    e.fs  = e.pix && (p == 0);
    q = n - 1 - pipe;
    if (q < 0) begin
      hq = 0; vq = 0; act = 0; hsr = 0; vsr = 0;
    end else begin
      hq  = (q % ft) % ht;
      vq  = (q % ft) / ht;
      act = (hq < ha) && (vq < va);
      hsr = (hq >= ha + hf) && (hq < ha + hf + hsn);
      vsr = (vq >= va + vf) && (vq < va + vf + vsn);
    end
    e.hs = hpol ? hsr : !hsr;
    e.vs = vpol ? vsr : !vsr;
    e.bn = act;
    e.r  = act ? hq % 256 : 0;
    e.g  = act ? vq % 256 : 0;
    e.b  = act ? bl : 0;
    return e;
  endfunction

  task automatic finish_sim();
    if (!done) begin
      done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
      if (errors >= 40) finish_sim();
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en && !done) begin
        e = model(mc, 2, 640, 16, 96, 48, 6, 2, 2, 2, 2, 1'b0, 1'b0, 'hA5);
        chk("pix_ce", 32'(pix_ce), 32'(e.pix));
        chk("x", 32'(x), e.x);
        chk("y", 32'(y), e.y);
        chk("req", 32'(req), 32'(e.req));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("vga_hs", 32'(vga_hs), 32'(e.hs));
        chk("vga_vs", 32'(vga_vs), 32'(e.vs));
        chk("vga_blank_n", 32'(vga_blank_n), 32'(e.bn));
        chk("vga_sync_n", 32'(vga_sync_n), 32'd0);
        chk("rgb", 32'({red, green, blue}), (e.r << 16) | (e.g << 8) | e.b);
        e = model(mc5, 1, 4, 1, 2, 1, 2, 1, 1, 1, 0, 1'b1, 1'b0, 'h3C);
        chk("s_pix_ce", 32'(pix_ce5), 32'(e.pix));
        chk("s_xy", 32'({x5, y5}), (e.x << 3) | e.y);
        chk("s_req", 32'(req5), 32'(e.req));
        chk("s_frame_start", 32'(fs5), 32'(e.fs));
        chk("s_hs", 32'(hs5), 32'(e.hs));
        chk("s_vs", 32'(vs5), 32'(e.vs));
        chk("s_blank_n", 32'(bn5), 32'(e.bn));
        chk("s_rgb", 32'({red5, green5, blue5}), (e.r << 16) | (e.g << 8) | e.b);
      end
    end
  end

  // Edge/interval measurements from reset release
  int cyc = 0;
  int hs_fall [2];
  int n_hs_fall = 0;
  int hs_low_len = -1;
  int fs_t [2];
  int n_fs = 0;
  int vs_fall = 0;
  int vs_low_len = -1;
  int rise_cyc = 0;
  int line_runs = 0;
  int run_len = -1;
  logic [23:0] first_px = 24'hFFFFFF;
  logic [23:0] px53 = 24'hFFFFFF;
  int hs5_rise [2];
  int n_hs5 = 0;
  int hs5_hi = -1;
  int fs5_t [2];
  int n_fs5 = 0;
  int last_x5 = -1, last_y5 = -1, wrap_x = -1, wrap_y = -1;

  initial begin
    bit p_hs, p_vs, p_bn, p_hs5;
    p_hs = 1; p_vs = 1; p_bn = 0; p_hs5 = 0;
    forever begin
      @(negedge clk);
      if (meas_en) begin
        cyc++;
        if (p_hs && !vga_hs) begin
          if (n_hs_fall < 2) hs_fall[n_hs_fall] = cyc;
          n_hs_fall++;
        end
        if (!p_hs && vga_hs && hs_low_len < 0) hs_low_len = cyc - hs_fall[0];
        if (frame_start) begin
          if (n_fs < 2) fs_t[n_fs] = cyc;
          n_fs++;
        end
        if (p_vs && !vga_vs) vs_fall = cyc;
        if (!p_vs && vga_vs && vs_low_len < 0) vs_low_len = cyc - vs_fall;
        if (!p_bn && vga_blank_n) begin
          rise_cyc = cyc;
          if (n_fs == 1) begin
            line_runs++;
            if (line_runs == 1) first_px = {red, green, blue};
          end
        end
        if (p_bn && !vga_blank_n && run_len < 0) run_len = cyc - rise_cyc;
        if (vga_blank_n && n_fs == 1 && line_runs == 4 && cyc - rise_cyc == 10)
          px53 = {red, green, blue};
        if (!p_hs5 && hs5) begin
          if (n_hs5 < 2) hs5_rise[n_hs5] = cyc;
          n_hs5++;
        end
        if (p_hs5 && !hs5 && hs5_hi < 0) hs5_hi = cyc - hs5_rise[0];
        if (fs5) begin
          if (n_fs5 < 2) fs5_t[n_fs5] = cyc;
          n_fs5++;
          if (n_fs5 == 2) begin
            wrap_x = last_x5;
            wrap_y = last_y5;
          end
        end
        if (pix_ce5) begin
          last_x5 = int'(x5);
          last_y5 = int'(y5);
        end
        p_hs = vga_hs; p_vs = vga_vs; p_bn = vga_blank_n; p_hs5 = hs5;
      end
    end
  end

  // Directed sequence
  initial begin
    int k, t_first, t_req, t_hs;
    bit found;
    reset  = 1'b1;
    reset5 = 1'b1;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pix_ce", 32'(pix_ce), 32'd0);
    chk("reset_xy", 32'({x, y}), 32'd0);
    chk("reset_hs_vs", 32'({vga_hs, vga_vs}), 32'b11);
    chk("reset_blank_n", 32'(vga_blank_n), 32'd0);
    chk("reset_rgb", 32'({red, green, blue}), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    chk("reset_s_hs", 32'(hs5), 32'd0);
    reset   = 1'b0;
    reset5  = 1'b0;
    meas_en = 1;

    // One full frame of the main instance plus margin
    found = 0;
    for (int i = 0; i < 25000 && !found; i++) begin
      @(negedge clk);
      if (n_fs >= 2) found = 1;
    end
    chk("frame_wait_timeout", 32'(found), 32'd1);

    chk("hs_period", hs_fall[1] - hs_fall[0], 1600);
    chk("hs_low_width", hs_low_len, 192);
    chk("frame_period", fs_t[1] - fs_t[0], 19200);
    chk("vs_low_width", vs_low_len, 3200);
    chk("blank_runs_per_frame", line_runs, 6);
    chk("blank_run_len", run_len, 1280);
    chk("first_pixel_rgb", 32'(first_px), 32'h0000A5);
    chk("pixel5_line3_rgb", 32'(px53), 32'h0503A5);
    chk("s_hs_period", hs5_rise[1] - hs5_rise[0], 8);
    chk("s_hs_high_width", hs5_hi, 2);
    chk("s_frame_period", fs5_t[1] - fs5_t[0], 40);
    chk("s_wrap_last_tick", (wrap_x << 8) | wrap_y, (7 << 8) | 4);

    // Mid-frame reset at (300,2)
    found = 0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(negedge clk);
      if (x == 10'd300 && y == 4'd2) found = 1;
    end
    chk("reset_point_timeout", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_xy", 32'({x, y}), 32'd0);
    chk("midreset_hs_vs", 32'({vga_hs, vga_vs}), 32'b11);
    chk("midreset_blank_n", 32'(vga_blank_n), 32'd0);
    chk("midreset_rgb", 32'({red, green, blue}), 32'd0);
    reset = 1'b0;

    // Edge counts from the reset edge: first tick, raw h=656 request, hs output fall
    k = 0; t_first = -1; t_req = -1; t_hs = -1;
    while (k < 3000 && t_hs < 0) begin
      @(posedge clk);
      k++;
      #1;
      if (pix_ce && t_first < 0) t_first = k;
      if (pix_ce && x == 10'd656 && t_req < 0) t_req = k;
      if (!vga_hs && t_hs < 0) t_hs = k;
    end
    chk("first_tick_after_reset", t_first, 2);
    chk("hs_request_after_reset", t_req - t_first, 1312);
    chk("hs_output_after_reset", t_hs - t_first, 1317);

    repeat (20) @(posedge clk);
    finish_sim();
  end

endmodule
`default_nettype wire
